// File: rtl/fpu_op_sequencer.sv
// rtl/fpu_op_sequencer.sv - queued FPU operation sequencer with timeout and in-order tagged responses
// Requests wait in a FIFO; each is issued over the start/operand protocol and answered over rsp_*.
module fpu_op_sequencer #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_op,
  input  logic [WIDTH-1:0]           req_a,
  input  logic [WIDTH-1:0]           req_b,
  input  logic [TAG_W-1:0]           req_tag,
  output logic                       fpu_start,
  output logic [1:0]                 fpu_op,
  output logic [WIDTH-1:0]           fpu_operand,
  input  logic                       fpu_ready_answer,
  input  logic                       fpu_error,
  input  logic [WIDTH-1:0]           fpu_answer,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_y,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic [1:0]                 rsp_err,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_FPU = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT, RESP} state_t;
  state_t state, state_d;

  logic [1:0]       op_mem  [DEPTH];
  logic [WIDTH-1:0] a_mem   [DEPTH];
  logic [WIDTH-1:0] b_mem   [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push, pop;

  logic [WIDTH-1:0] b_r, b_d;
  logic [TAG_W-1:0] tag_r, tag_d;
  logic [TW-1:0]    wcnt, wcnt_d;
  logic             start_d, rv_d;
  logic [1:0]       fop_d, err_d;
  logic [WIDTH-1:0] operand_d, y_d;
  logic [TAG_W-1:0] rtag_d;

  assign req_ready = (cnt != CW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && (cnt != '0);
  assign count     = cnt;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]  <= req_op;
      a_mem[wr_ptr]   <= req_a;
      b_mem[wr_ptr]   <= req_b;
      tag_mem[wr_ptr] <= req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      b_r         <= '0;
      tag_r       <= '0;
      wcnt        <= '0;
      fpu_start   <= 1'b0;
      fpu_op      <= 2'd0;
      fpu_operand <= '0;
      rsp_valid   <= 1'b0;
      rsp_y       <= '0;
      rsp_tag     <= '0;
      rsp_err     <= ERR_OK;
    end else begin
      state       <= state_d;
      b_r         <= b_d;
      tag_r       <= tag_d;
      wcnt        <= wcnt_d;
      fpu_start   <= start_d;
      fpu_op      <= fop_d;
      fpu_operand <= operand_d;
      rsp_valid   <= rv_d;
      rsp_y       <= y_d;
      rsp_tag     <= rtag_d;
      rsp_err     <= err_d;
    end
  end

  // Next values of the registered outputs are computed here so each output appears one cycle after its state decision.
  always_comb begin
    state_d   = state;
    b_d       = b_r;
    tag_d     = tag_r;
    wcnt_d    = wcnt;
    start_d   = 1'b0;
    fop_d     = fpu_op;
    operand_d = '0;
    rv_d      = rsp_valid;
    y_d       = rsp_y;
    rtag_d    = rsp_tag;
    err_d     = rsp_err;
    case (state)
      IDLE: begin
        if (pop) begin
          b_d   = b_mem[rd_ptr];
          tag_d = tag_mem[rd_ptr];
          if (op_mem[rd_ptr] == OP_NOP) begin
            state_d = RESP;
            rv_d    = 1'b1;
            y_d     = '0;
            rtag_d  = tag_mem[rd_ptr];
            err_d   = ERR_OK;
          end else begin
            state_d   = SEND_A;
            start_d   = 1'b1;
            fop_d     = op_mem[rd_ptr];
            operand_d = a_mem[rd_ptr];
          end
        end
      end
      SEND_A: begin
        state_d   = SEND_B;
        operand_d = b_r;
      end
      SEND_B: begin
        state_d = WAIT;
        wcnt_d  = '0;
      end
      WAIT: begin
        wcnt_d = wcnt + TW'(1);
        if (fpu_ready_answer) begin
          state_d = RESP;
          rv_d    = 1'b1;
          y_d     = fpu_error ? '1 : fpu_answer;
          err_d   = fpu_error ? ERR_FPU : ERR_OK;
          rtag_d  = tag_r;
          fop_d   = 2'd0;
        end else if (wcnt == TW'(TIMEOUT-1)) begin
          state_d = RESP;
          rv_d    = 1'b1;
          y_d     = '1;
          err_d   = ERR_TMO;
          rtag_d  = tag_r;
          fop_d   = 2'd0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rv_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb/tb_fpu_op_sequencer.sv - directed bench for fpu_op_sequencer with a response scoreboard
// An FPU stand-in answers each issued op after a per-request delay; a scoreboard predicts every response.
module tb_fpu_op_sequencer;
  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 8;
  localparam int CW      = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid, req_ready;
  logic [1:0]        req_op;
  logic [WIDTH-1:0]  req_a, req_b;
  logic [TAG_W-1:0]  req_tag;
  logic              fpu_start;
  logic [1:0]        fpu_op;
  logic [WIDTH-1:0]  fpu_operand;
  logic              fpu_ready_answer, fpu_error;
  logic [WIDTH-1:0]  fpu_answer;
  logic              rsp_valid, rsp_ready;
  logic [WIDTH-1:0]  rsp_y;
  logic [TAG_W-1:0]  rsp_tag;
  logic [1:0]        rsp_err;
  logic [CW-1:0]     count;
  logic              busy;

  always #5 clk = ~clk;

  fpu_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_operand(fpu_operand),
    .fpu_ready_answer(fpu_ready_answer), .fpu_error(fpu_error), .fpu_answer(fpu_answer),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .count(count), .busy(busy)
  );

  // delay = extra WAIT cycles before the FPU answers; negative means it never answers
  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] a, b;
    logic [TAG_W-1:0] tag;
    int               delay;
    logic             ferr;
    logic [WIDTH-1:0] ans;
  } req_t;
  typedef struct {
    logic [WIDTH-1:0] y;
    logic [TAG_W-1:0] tag;
    logic [1:0]       err;
  } rsp_t;

  req_t issue_q[$];
  rsp_t exp_q[$];
  req_t cur_issue;
  int   errors = 0;
  int   checks = 0;
  int   rsp_seen = 0;
  int   req_delay;
  logic req_ferr;
  logic [WIDTH-1:0] req_ans;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rsp_t model_rsp(input req_t r);
    rsp_t s;
    s.tag = r.tag;
    if (r.op == 2'd0) begin
      s.y = '0; s.err = 2'd0;
    end else if (r.delay < 0 || r.delay >= TIMEOUT) begin
      s.y = '1; s.err = 2'd2;
    end else if (r.ferr) begin
      s.y = '1; s.err = 2'd1;
    end else begin
      s.y = r.ans; s.err = 2'd0;
    end
    return s;
  endfunction

  // FPU stand-in
  initial begin
    req_t r;
    fpu_ready_answer = 1'b0; fpu_error = 1'b0; fpu_answer = '0;
    forever begin
      @(negedge clk);
      if (!rst && fpu_start) begin
        #1;
        r = cur_issue;
        if (r.delay >= 0) begin
          @(posedge clk); @(posedge clk);
          repeat (r.delay) @(posedge clk);
          #1;
          fpu_ready_answer = 1'b1; fpu_error = r.ferr; fpu_answer = r.ans;
          @(posedge clk); #1;
          fpu_ready_answer = 1'b0; fpu_error = 1'b0; fpu_answer = '0;
        end
      end
    end
  end

  // Compare process: scoreboard, issue protocol and response hold checks
  initial begin
    req_t r;
    rsp_t e;
    logic hold_v, chk_b;
    logic [WIDTH-1:0] hy, eb;
    logic [TAG_W-1:0] ht;
    logic [1:0] he, eop;
    hold_v = 1'b0; chk_b = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete(); issue_q.delete();
        hold_v = 1'b0; chk_b = 1'b0;
      end else begin
        if (hold_v) begin
          check("rsp_hold_valid", rsp_valid, 1);
          check("rsp_hold_y", rsp_y, hy);
          check("rsp_hold_tag", rsp_tag, ht);
          check("rsp_hold_err", rsp_err, he);
        end
        if (fpu_start) begin
          if (issue_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_issue: fpu_start high with op %0h, none expected", fpu_op);
          end else begin
            r = issue_q.pop_front();
            cur_issue = r;
            check("issue_op", fpu_op, r.op);
            check("issue_a", fpu_operand, r.a);
            eb = r.b; eop = r.op; chk_b = 1'b1;
          end
        end else if (chk_b) begin
          check("issue_b", fpu_operand, eb);
          check("issue_op_b", fpu_op, eop);
          chk_b = 1'b0;
        end else begin
          check("idle_operand", fpu_operand, 0);
        end
        if (rsp_valid && rsp_ready) begin
          rsp_seen++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: tag %0h with none expected", rsp_tag);
          end else begin
            e = exp_q.pop_front();
            check("rsp_tag", rsp_tag, e.tag);
            check("rsp_y", rsp_y, e.y);
            check("rsp_err", rsp_err, e.err);
          end
        end
        hold_v = rsp_valid && !rsp_ready;
        hy = rsp_y; ht = rsp_tag; he = rsp_err;
        if (req_valid && req_ready) begin
          r.op = req_op; r.a = req_a; r.b = req_b; r.tag = req_tag;
          r.delay = req_delay; r.ferr = req_ferr; r.ans = req_ans;
          exp_q.push_back(model_rsp(r));
          if (r.op != 2'd0) issue_q.push_back(r);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [TAG_W-1:0] tag, input int delay, input logic ferr,
                           input logic [WIDTH-1:0] ans);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    req_delay = delay; req_ferr = ferr; req_ans = ans;
  endtask

  task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [TAG_W-1:0] tag, input int delay, input logic ferr,
                      input logic [WIDTH-1:0] ans);
    int n;
    drive_req(op, a, b, tag, delay, ferr, ans);
    n = 0;
    while (!req_ready && n < 200) begin tick(); n++; end
    check("send_accept", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output int n);
    n = 0;
    while (!rsp_valid && n < max) begin tick(); n++; end
    check("wait_rsp_bound", rsp_valid, 1);
  endtask

  initial begin
    int n, k, base;
    logic rdy;
    int exp_cnt[6];
    exp_cnt = '{0, 1, 1, 2, 3, 4};
    req_valid = 1'b0; req_op = 2'd0; req_a = '0; req_b = '0; req_tag = '0;
    req_delay = 0; req_ferr = 1'b0; req_ans = '0; rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_fpu_start", fpu_start, 0);
    check("rst_fpu_op", fpu_op, 0);
    check("rst_operand", fpu_operand, 0);
    check("rst_count", count, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_y", rsp_y, 0);
    check("rst_rsp_tag", rsp_tag, 0);
    check("rst_rsp_err", rsp_err, 0);
    rst = 1'b0;
    tick();

    // ADD 1.0 + 2.0, answered in the first WAIT cycle
    rsp_ready = 1'b1;
    drive_req(2'd3, 32'h3F800000, 32'h40000000, 4'd3, 0, 1'b0, 32'h40400000);
    tick(); req_valid = 1'b0;
    check("add_c1_start", fpu_start, 0);
    check("add_c1_busy", busy, 0);
    tick();
    check("add_c2_start", fpu_start, 1);
    check("add_c2_operand", fpu_operand, 32'h3F800000);
    check("add_c2_op", fpu_op, 3);
    tick();
    check("add_c3_start", fpu_start, 0);
    check("add_c3_operand", fpu_operand, 32'h40000000);
    tick();
    check("add_c4_valid", rsp_valid, 0);
    check("add_c4_busy", busy, 1);
    tick();
    check("add_c5_valid", rsp_valid, 1);
    check("add_c5_y", rsp_y, 32'h40400000);
    check("add_c5_tag", rsp_tag, 3);
    check("add_c5_err", rsp_err, 0);
    tick();
    check("add_c6_valid", rsp_valid, 0);

    // NOP answers without FPU traffic
    drive_req(2'd0, 32'h11111111, 32'h22222222, 4'd5, 0, 1'b0, '0);
    tick(); req_valid = 1'b0;
    check("nop_c1_valid", rsp_valid, 0);
    check("nop_c1_start", fpu_start, 0);
    tick();
    check("nop_c2_valid", rsp_valid, 1);
    check("nop_c2_y", rsp_y, 0);
    check("nop_c2_err", rsp_err, 0);
    check("nop_c2_tag", rsp_tag, 5);
    check("nop_c2_start", fpu_start, 0);
    tick();

    // MULTIPLY with FPU error flag
    send(2'd2, 32'h40400000, 32'h40800000, 4'd9, 1, 1'b1, 32'h12345678);
    wait_rsp(40, n);
    check("mul_err_latency", n, 5);
    check("mul_err_y", rsp_y, 32'hFFFFFFFF);
    check("mul_err_err", rsp_err, 1);
    tick();

    // Timeout with a second ADD queued behind it
    drive_req(2'd3, 32'h40A00000, 32'h3F800000, 4'd7, -1, 1'b0, '0);
    tick();
    drive_req(2'd3, 32'h40000000, 32'h40400000, 4'd8, 0, 1'b0, 32'h40A00000);
    tick(); req_valid = 1'b0;
    check("tmo_c2_count", count, 1);
    for (int c = 2; c < 12; c++) begin
      check("tmo_early_valid", rsp_valid, 0);
      tick();
    end
    check("tmo_c12_valid", rsp_valid, 1);
    check("tmo_c12_err", rsp_err, 2);
    check("tmo_c12_y", rsp_y, 32'hFFFFFFFF);
    check("tmo_c12_tag", rsp_tag, 7);
    tick();
    repeat (3) tick();
    check("tmo_c16_valid", rsp_valid, 0);
    tick();
    check("tmo2_c17_valid", rsp_valid, 1);
    check("tmo2_c17_tag", rsp_tag, 8);
    check("tmo2_c17_y", rsp_y, 32'h40A00000);
    check("tmo2_c17_err", rsp_err, 0);
    tick();

    // Answer on the last WAIT cycle wins; one cycle later is a timeout
    send(2'd3, 32'h1, 32'h2, 4'd10, TIMEOUT-1, 1'b0, 32'h41000000);
    wait_rsp(40, n);
    check("edge_ans_latency", n, 11);
    check("edge_ans_err", rsp_err, 0);
    check("edge_ans_y", rsp_y, 32'h41000000);
    tick();
    send(2'd1, 32'h3, 32'h4, 4'd11, TIMEOUT, 1'b0, 32'h41100000);
    wait_rsp(40, n);
    check("edge_tmo_latency", n, 11);
    check("edge_tmo_err", rsp_err, 2);
    tick();

    // Back-pressure: FIFO fills while the first response is held
    rsp_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      if (k < 7) drive_req(2'd3, 32'(k), 32'h0, 4'(k), 0, 1'b0, 32'h100 + 32'(k));
      else req_valid = 1'b0;
      if (c <= 5) begin
        check("fill_count", count, exp_cnt[c]);
        check("fill_req_ready", req_ready, (c < 5) ? 1 : 0);
      end else begin
        check("full_count", count, 4);
        check("full_req_ready", req_ready, 0);
      end
      rdy = req_ready;
      tick();
      if (rdy && k < 7) k++;
    end
    check("fill_accepted", k, 5);
    check("fill_head_tag", rsp_tag, 0);
    base = rsp_seen;
    rsp_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (k < 7) drive_req(2'd3, 32'(k), 32'h0, 4'(k), 0, 1'b0, 32'h100 + 32'(k));
      else req_valid = 1'b0;
      rdy = req_ready;
      tick();
      if (rdy && k < 7) k++;
      if (k == 7 && rsp_seen == base + 7) break;
    end
    req_valid = 1'b0;
    check("drain_accepted", k, 7);
    check("drain_responses", rsp_seen - base, 7);
    tick();

    // Reset during WAIT while the FPU answers
    drive_req(2'd3, 32'h5, 32'h6, 4'd12, 2, 1'b0, 32'h41200000);
    tick();
    drive_req(2'd3, 32'h7, 32'h8, 4'd13, 0, 1'b0, 32'h41300000);
    tick(); req_valid = 1'b0;
    repeat (4) tick();
    check("rst_wait_busy", busy, 1);
    check("rst_wait_count", count, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_start", fpu_start, 0);
    check("midrst_count", count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_req_ready", req_ready, 1);
    base = rsp_seen;
    repeat (20) tick();
    check("midrst_no_rsp", rsp_seen - base, 0);
    check("midrst_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
